// File: rtl/sdram_cmd_responder.sv
// Single-bank SDRAM device model: decodes CS/RAS/CAS/WE/CKE, enforces bank timers, stores writes.
// Latency: read data valid in the cycle sampled at edge N+CL; errors flagged one cycle after the offending edge.
// Backpressure: none; illegal or early commands are dropped and reported on err_o/err_code_o.
module sdram_cmd_responder #(
  parameter int RSC_p       = 2,
  parameter int RP_p        = 2,
  parameter int RCD_p       = 2,
  parameter int XSR_p       = 75,
  parameter int cas_laten_p = 2,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 4,
  parameter int DATA_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_i,
  input  logic              ras_i,
  input  logic              cas_i,
  input  logic              we_i,
  input  logic              cke_i,
  input  logic [ROW_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] dq_i,
  output logic [DATA_W-1:0] dq_o,
  output logic              dq_oe_o,
  output logic [2:0]        state_o,
  output logic [1:0]        cl_o,
  output logic              err_o,
  output logic [2:0]        err_code_o
);

  localparam int MW   = ROW_W + COL_W;
  localparam int TM1  = (RSC_p > RP_p) ? RSC_p : RP_p;
  localparam int TM2  = (TM1 > RCD_p) ? TM1 : RCD_p;
  localparam int TMAX = (TM2 > XSR_p) ? TM2 : XSR_p;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACT  = 3'd2,
    ST_SREF = 3'd3,
    ST_XSR  = 3'd4
  } state_t;

  state_t            state_q, state_d, ret_q, ret_d, go_ret;
  logic [TW-1:0]     tmr_q, tmr_d, go_len;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        cl_q, cl_d;
  logic              go_wait, rd_go, wr_go;
  logic              e1, e2, e3, e4, e5;
  logic              err_q;
  logic [2:0]        err_code_q, err_code_d;
  logic              s1_vld, s2_vld, oe_q;
  logic [DATA_W-1:0] s1_dat, s2_dat, dq_q, rd_dat;
  logic [DATA_W-1:0] mem [0:(2**MW)-1];

  logic [3:0] cmd;
  logic [2:0] mode;
  logic is_idle, is_pre, is_lm, is_act, is_rd, is_wr, is_ref, is_sre, is_bad;

  assign cmd     = {cs_i, ras_i, cas_i, we_i};
  // Mode field sits at address bits [6:4]; narrower buses read it as zero.
  assign mode    = 3'(addr_i >> 4);
  assign is_idle = cs_i || (cmd == 4'b0111);
  assign is_pre  = (cmd == 4'b0010);
  assign is_lm   = (cmd == 4'b0000);
  assign is_act  = (cmd == 4'b0011);
  assign is_rd   = (cmd == 4'b0101);
  assign is_wr   = (cmd == 4'b0100);
  assign is_ref  = (cmd == 4'b0001) && cke_i;
  assign is_sre  = (cmd == 4'b0001) && !cke_i;
  assign is_bad  = (cmd == 4'b0110);

  assign rd_dat  = mem[{row_q, addr_i[COL_W-1:0]}];

  // Next-state, timer, and error-cause decode for the bank.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    tmr_d   = tmr_q;
    row_d   = row_q;
    cl_d    = cl_q;
    go_wait = 1'b0;
    go_ret  = ST_IDLE;
    go_len  = '0;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; e4 = 1'b0; e5 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cke_i && !is_idle && !is_sre) e4 = 1'b1;
        else if (is_pre || is_ref) begin
          go_wait = 1'b1; go_ret = ST_IDLE; go_len = TW'(RP_p - 1);
        end else if (is_lm) begin
          if (mode == 3'd2 || mode == 3'd3) begin
            cl_d = mode[1:0];
            go_wait = 1'b1; go_ret = ST_IDLE; go_len = TW'(RSC_p - 1);
          end else e3 = 1'b1;
        end else if (is_act) begin
          row_d = addr_i;
          go_wait = 1'b1; go_ret = ST_ACT; go_len = TW'(RCD_p - 1);
        end else if (is_sre) state_d = ST_SREF;
        else if (is_rd || is_wr) e2 = 1'b1;
        else if (is_bad) e5 = 1'b1;
      end
      ST_ACT: begin
        if (!cke_i && !is_idle) e4 = 1'b1;
        else if (is_pre) begin
          go_wait = 1'b1; go_ret = ST_IDLE; go_len = TW'(RP_p - 1);
        end else if (is_rd) rd_go = 1'b1;
        else if (is_wr) wr_go = 1'b1;
        else if (is_act || is_lm || is_ref) e2 = 1'b1;
        else if (is_bad) e5 = 1'b1;
      end
      ST_WAIT: begin
        if (!is_idle) e1 = 1'b1;
        if (tmr_q <= TW'(1)) begin
          state_d = ret_q;
          tmr_d   = '0;
        end else tmr_d = tmr_q - TW'(1);
      end
      ST_SREF: begin
        if (cke_i) begin
          go_wait = 1'b1; go_ret = ST_IDLE; go_len = TW'(XSR_p - 1);
        end
      end
      ST_XSR: begin
        if (!cke_i) begin
          e4      = 1'b1;
          state_d = ST_SREF;
          tmr_d   = '0;
        end else begin
          if (!is_idle) e1 = 1'b1;
          if (tmr_q <= TW'(1)) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end else tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A zero-length wait falls straight through to the return state.
    if (go_wait) begin
      if (go_len == '0) state_d = go_ret;
      else begin
        state_d = (state_q == ST_SREF) ? ST_XSR : ST_WAIT;
        ret_d   = go_ret;
        tmr_d   = go_len;
      end
    end
  end

  // Error cause priority 4 > 1 > 2 > 3 > 5.
  always_comb begin
    err_code_d = 3'd0;
    if (e4)      err_code_d = 3'd4;
    else if (e1) err_code_d = 3'd1;
    else if (e2) err_code_d = 3'd2;
    else if (e3) err_code_d = 3'd3;
    else if (e5) err_code_d = 3'd5;
  end

  // Bank state, timer, row, CL and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      tmr_q      <= '0;
      row_q      <= '0;
      cl_q       <= 2'(cas_laten_p);
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      tmr_q      <= tmr_d;
      row_q      <= row_d;
      cl_q       <= cl_d;
      err_q      <= e1 | e2 | e3 | e4 | e5;
      err_code_q <= err_code_d;
    end
  end

  // Read pipeline: CL=3 reads enter stage 2, CL=2 reads enter stage 1; stage 1 feeds the output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
      s1_vld <= 1'b0;
      s1_dat <= '0;
      oe_q   <= 1'b0;
      dq_q   <= '0;
    end else begin
      s2_vld <= rd_go && (cl_q == 2'd3);
      s2_dat <= rd_dat;
      s1_vld <= s2_vld || (rd_go && (cl_q != 2'd3));
      s1_dat <= (rd_go && (cl_q != 2'd3)) ? rd_dat : s2_dat;
      oe_q   <= s1_vld;
      dq_q   <= s1_vld ? s1_dat : '0;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_go) mem[{row_q, addr_i[COL_W-1:0]}] <= dq_i;
  end

  assign dq_o       = dq_q;
  assign dq_oe_o    = oe_q;
  assign state_o    = state_q;
  assign cl_o       = cl_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed commands, expected reads/errors queued with their due cycle.
// A negedge monitor pops and compares whenever dq_oe_o or err_o is seen, and flags missed items.
module tb_sdram_cmd_responder;

  localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_LM = 4'b0000, C_ACT = 4'b0011,
                         C_RD = 4'b0101, C_WR = 4'b0100, C_REF = 4'b0001, C_BAD = 4'b0110;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cs_i = 1'b0, ras_i = 1'b1, cas_i = 1'b1, we_i = 1'b1;
  logic        cke_i = 1'b1;
  logic [7:0]  addr_i = '0;
  logic [15:0] dq_i = '0;
  logic [15:0] dq_o;
  logic        dq_oe_o;
  logic [2:0]  state_o;
  logic [1:0]  cl_o;
  logic        err_o;
  logic [2:0]  err_code_o;

  sdram_cmd_responder #(.ROW_W(8), .COL_W(4), .DATA_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cs_i(cs_i), .ras_i(ras_i), .cas_i(cas_i), .we_i(we_i),
    .cke_i(cke_i), .addr_i(addr_i), .dq_i(dq_i), .dq_o(dq_o), .dq_oe_o(dq_oe_o),
    .state_o(state_o), .cl_o(cl_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int tag; int val; } exp_t;
  exp_t rd_q[$];
  exp_t err_q[$];
  int   cyc = 0;
  int   last_edge = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk_i) cyc++;

  // Monitor: outputs seen at the negedge after edge cyc.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (dq_oe_o) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++; $display("FAIL rd_unexpected edge=%0d got=%h", cyc, dq_o);
        end else begin
          e = rd_q.pop_front();
          if (e.tag != cyc || e.val != int'(dq_o)) begin
            bad++; $display("FAIL rd_data edge=%0d got=%h want=%h at edge %0d", cyc, dq_o, e.val[15:0], e.tag);
          end
        end
      end else if (rd_q.size() > 0 && rd_q[0].tag <= cyc) begin
        e = rd_q.pop_front();
        total++; bad++;
        $display("FAIL rd_missing edge=%0d got=none want=%h", cyc, e.val[15:0]);
      end
      if (err_o) begin
        total++;
        if (err_q.size() == 0) begin
          bad++; $display("FAIL err_unexpected edge=%0d got_code=%0d want=none", cyc, err_code_o);
        end else begin
          e = err_q.pop_front();
          if (e.tag != cyc || e.val != int'(err_code_o)) begin
            bad++; $display("FAIL err_code edge=%0d got=%0d want=%0d at edge %0d", cyc, err_code_o, e.val, e.tag);
          end
        end
      end else if (err_q.size() > 0 && err_q[0].tag <= cyc) begin
        e = err_q.pop_front();
        total++; bad++;
        $display("FAIL err_missing edge=%0d got=none want=%0d", cyc, e.val);
      end
    end
  end

  // Issue one command on the next edge, then return to NOP #1 after that edge.
  task automatic cmd(input logic [3:0] c, input logic [7:0] a, input logic [15:0] d, input logic ck);
    @(negedge clk_i);
    last_edge = cyc + 1;
    {cs_i, ras_i, cas_i, we_i} = c;
    addr_i = a;
    dq_i   = d;
    cke_i  = ck;
    @(posedge clk_i);
    #1;
    {cs_i, ras_i, cas_i, we_i} = C_NOP;
  endtask

  task automatic nop(input int n, input logic ck);
    for (int i = 0; i < n; i++) cmd(C_NOP, 8'h00, 16'h0, ck);
  endtask

  task automatic exp_err(input int code);
    exp_t e;
    e.tag = last_edge; e.val = code;
    err_q.push_back(e);
  endtask

  task automatic exp_rd(input int data, input int cl);
    exp_t e;
    e.tag = last_edge + cl - 1; e.val = data;
    rd_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_state"}, state_o, 0);
    chk({nm, "_cl"}, cl_o, 2);
    chk({nm, "_oe"}, dq_oe_o, 0);
    chk({nm, "_dq"}, dq_o, 0);
    chk({nm, "_err"}, err_o, 0);
    chk({nm, "_code"}, err_code_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk_reset_outputs("rst0");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Write then read back with CL=2; preload cols 1..3.
    cmd(C_ACT, 8'h05, 16'h0, 1'b1);
    chk("act_wait_state", state_o, 1);
    nop(1, 1'b1);
    chk("act_open_state", state_o, 2);
    cmd(C_WR, 8'h09, 16'hBEEF, 1'b1);
    cmd(C_RD, 8'h09, 16'h0, 1'b1); exp_rd(16'hBEEF, 2);
    cmd(C_WR, 8'h01, 16'h0011, 1'b1);
    cmd(C_WR, 8'h02, 16'h0022, 1'b1);
    cmd(C_WR, 8'h03, 16'h0033, 1'b1);
    cmd(C_PRE, 8'h00, 16'h0, 1'b1);
    nop(1, 1'b1);
    chk("pre_idle_state", state_o, 0);

    // Precharge from idle, mode load to CL=3, RSC enforcement.
    cmd(C_PRE, 8'h00, 16'h0, 1'b1);
    nop(1, 1'b1);
    cmd(C_LM, 8'h30, 16'h0, 1'b1);
    chk("lm_cl3", cl_o, 3);
    chk("lm_wait_state", state_o, 1);
    cmd(C_ACT, 8'h05, 16'h0, 1'b1); exp_err(1);
    chk("early_act_idle", state_o, 0);
    cmd(C_ACT, 8'h05, 16'h0, 1'b1);
    nop(1, 1'b1);
    chk("act2_open_state", state_o, 2);

    // Back-to-back reads at CL=3 followed by precharge.
    cmd(C_RD, 8'h01, 16'h0, 1'b1); exp_rd(16'h0011, 3);
    cmd(C_RD, 8'h02, 16'h0, 1'b1); exp_rd(16'h0022, 3);
    cmd(C_RD, 8'h03, 16'h0, 1'b1); exp_rd(16'h0033, 3);
    cmd(C_PRE, 8'h00, 16'h0, 1'b1);
    nop(3, 1'b1);

    // Error causes from idle.
    cmd(C_RD, 8'h01, 16'h0, 1'b1); exp_err(2);
    chk("rd_idle_state", state_o, 0);
    cmd(C_LM, 8'h10, 16'h0, 1'b1); exp_err(3);
    chk("bad_mode_cl", cl_o, 3);
    chk("bad_mode_state", state_o, 0);
    cmd(C_BAD, 8'h00, 16'h0, 1'b1); exp_err(5);
    cmd(C_ACT, 8'h05, 16'h0, 1'b0); exp_err(4);
    chk("cke_low_act_state", state_o, 0);

    // Self refresh and XSR window.
    cmd(C_REF, 8'h00, 16'h0, 1'b0);
    chk("sref_state", state_o, 3);
    nop(4, 1'b0);
    cmd(C_ACT, 8'h05, 16'h0, 1'b0);
    nop(4, 1'b0);
    chk("sref_hold_state", state_o, 3);
    cmd(C_NOP, 8'h00, 16'h0, 1'b1);
    n = last_edge;
    chk("xsr_state", state_o, 4);
    nop(73, 1'b1);
    chk("xsr_edge", last_edge, n + 73);
    chk("xsr_still", state_o, 4);
    cmd(C_ACT, 8'h05, 16'h0, 1'b1); exp_err(1);
    chk("xsr_done_idle", state_o, 0);
    cmd(C_ACT, 8'h05, 16'h0, 1'b1);
    chk("xsr_act_accept", state_o, 1);
    nop(1, 1'b1);

    // Reset with a read in flight: no data may appear.
    cmd(C_RD, 8'h09, 16'h0, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_rd");
    nop(4, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset in the middle of XSR.
    cmd(C_REF, 8'h00, 16'h0, 1'b0);
    nop(2, 1'b0);
    nop(5, 1'b1);
    chk("xsr2_state", state_o, 4);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rst_xsr");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Array contents survive reset; CL back to 2.
    cmd(C_ACT, 8'h05, 16'h0, 1'b1);
    nop(1, 1'b1);
    cmd(C_RD, 8'h09, 16'h0, 1'b1); exp_rd(16'hBEEF, 2);
    nop(6, 1'b1);

    chk("rd_queue_empty", rd_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
